// File: rtl/seq_bit_serializer_if.sv
// Parallel word handshake into the bit serializer.
// The source drives the word; the serializer returns ready.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_msb_first;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    output din_msb_first,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    input  din_msb_first,
    output din_ready
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: one-entry buffer feeding a shifter
// that emits one bit per clock with framing strobes and a word count.
module seq_bit_serializer #(
  parameter int   WIDTH      = 7,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_BIT   = 1'b0,
  parameter int   CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_bit_serializer_if.slave  in_if,
  output logic                 x,
  output logic                 x_valid,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 busy,
  output logic [CNT_W-1:0]     words_sent
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LD = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LD =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic               buf_msb_q, buf_msb_d;
  logic               buf_full_q, buf_full_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic               msb_q, msb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         gap_q, gap_d;
  logic               x_q, x_d;
  logic               xv_q, xv_d;
  logic               fs_q, fs_d;
  logic               fe_q, fe_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               accept;
  logic               load;

  assign in_if.din_ready = !rst && !buf_full_q;
  assign accept = in_if.din_valid && in_if.din_ready;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_msb_d  = buf_msb_q;
    buf_full_d = buf_full_q;
    sh_d       = sh_q;
    msb_d      = msb_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    words_d    = words_q;
    x_d        = IDLE_BIT;
    xv_d       = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    load       = 1'b0;

    if (accept) begin
      buf_d      = in_if.din;
      buf_msb_d  = in_if.din_msb_first;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (buf_full_q) load = 1'b1;
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          x_d   = msb_q ? sh_q[WIDTH-1] : sh_q[0];
          sh_d  = msb_q ? (sh_q << 1) : (sh_q >> 1);
          cnt_d = cnt_q - 1'b1;
          xv_d  = 1'b1;
          fe_d  = (cnt_q == CW'(1));
        end else begin
          if (words_q != {CNT_W{1'b1}}) words_d = words_q + 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LD;
          end else if (buf_full_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
        else if (buf_full_q) load = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The first bit goes straight to x; the rest stays in the shifter.
    if (load) begin
      state_d    = SHIFT;
      buf_full_d = 1'b0;
      msb_d      = buf_msb_q;
      x_d        = buf_msb_q ? buf_q[WIDTH-1] : buf_q[0];
      sh_d       = buf_msb_q ? (buf_q << 1) : (buf_q >> 1);
      cnt_d      = CNT_LD;
      xv_d       = 1'b1;
      fs_d       = 1'b1;
      fe_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_msb_q  <= 1'b0;
      buf_full_q <= 1'b0;
      sh_q       <= '0;
      msb_q      <= 1'b0;
      cnt_q      <= '0;
      gap_q      <= '0;
      x_q        <= IDLE_BIT;
      xv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_msb_q  <= buf_msb_d;
      buf_full_q <= buf_full_d;
      sh_q       <= sh_d;
      msb_q      <= msb_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      x_q        <= x_d;
      xv_q       <= xv_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      words_q    <= words_d;
    end
  end

  assign x           = x_q;
  assign x_valid     = xv_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign words_sent  = words_q;
  assign busy        = (state_q != IDLE) || buf_full_q;

endmodule
